// File: rtl/dom_pkg.sv
// ---------------------------------------------------------------------------
// dom_pkg
//   Shared constants and helpers for the DOM multiplier scheduling slice.
//   - SHARES_DEF : default share count of the masked datapath
//   - share_w()  : width of one GF(2^2) operand in shared form (2*SHARES)
//   - rnd_w()    : width of the fresh randomness for one DOM multiplication
//   - clog2()    : ceiling log2, never smaller than 1 so it can size an index
//   No ports (package).
// ---------------------------------------------------------------------------
package dom_pkg;

  localparam int SHARES_DEF = 2;

  function automatic int share_w(input int shares);
    return 2 * shares;
  endfunction

  function automatic int rnd_w(input int shares);
    return shares * (shares - 1);
  endfunction

  // A result of 1 for n<=2 keeps single-entry selects legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 30; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dom_rsp_fifo.sv
// ---------------------------------------------------------------------------
// dom_rsp_fifo
//   Small synchronous FIFO holding multiplier responses until the consumer
//   takes them. Push and pop in the same cycle are allowed, including when
//   the FIFO is full (the slot being read is the slot being overwritten).
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     push        : write push_data this cycle
//     push_data   : entry to store
//     pop         : consume the head this cycle (ignored when empty)
//     pop_data    : head entry
//     valid       : FIFO not empty
//     count       : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module dom_rsp_fifo
  import dom_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          valid,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop_eff;

  assign valid    = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop & valid;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy. Pointers wrap explicitly so DEPTH need
  // not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop_eff));

endmodule

// File: rtl/dom_mul_sched.sv
// ---------------------------------------------------------------------------
// dom_mul_sched
//   Round-robin scheduler sharing one pipelined DOM GF(2^2) multiplier
//   between NREQ requesters. An issue needs a valid request, fresh
//   randomness and a free response slot; the granted operands and the
//   randomness go to the multiplier in the same cycle. A tag pipe follows
//   the multiplier latency so each product is stored with its requester
//   index in a response FIFO, in issue order.
//
//   Build option DOM_SCHED_IDLE_ZERO_EN:
//     defined     : multiplier operands forced to zero in non-issue cycles
//     not defined : multiplier operands hold the last issued values
//
//   Ports:
//     ClkxCI, RstxBI : clock (rising edge), asynchronous active-low reset
//     ReqValidxSI    : request valid per requester
//     ReqReadyxSO    : one-hot grant (or zero) this cycle
//     ReqXxDI/ReqYxDI: operand shares, requester r at [r*2*SHARES +: 2*SHARES]
//     RndxDI/RndValidxSI/RndReadyxSO : fresh randomness handshake
//     MulXxDO/MulYxDO/MulZxDO : operands to the multiplier
//     MulQxDI        : product shares from the multiplier
//     RspValidxSO/RspIdxDO/RspQxDO/RspReadyxSI : response FIFO head
// ---------------------------------------------------------------------------
module dom_mul_sched
  import dom_pkg::*;
#(
  parameter int SHARES  = SHARES_DEF,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  parameter int RSP_DEP = 2
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  input  logic [NREQ-1:0]               ReqValidxSI,
  output logic [NREQ-1:0]               ReqReadyxSO,
  input  logic [NREQ*share_w(SHARES)-1:0] ReqXxDI,
  input  logic [NREQ*share_w(SHARES)-1:0] ReqYxDI,
  input  logic [rnd_w(SHARES)-1:0]      RndxDI,
  input  logic                          RndValidxSI,
  output logic                          RndReadyxSO,
  output logic [share_w(SHARES)-1:0]    MulXxDO,
  output logic [share_w(SHARES)-1:0]    MulYxDO,
  output logic [rnd_w(SHARES)-1:0]      MulZxDO,
  input  logic [share_w(SHARES)-1:0]    MulQxDI,
  output logic                          RspValidxSO,
  output logic [clog2(NREQ)-1:0]        RspIdxDO,
  output logic [share_w(SHARES)-1:0]    RspQxDO,
  input  logic                          RspReadyxSI
);

  localparam int SW = share_w(SHARES);
  localparam int RW = rnd_w(SHARES);
  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(RSP_DEP + 1);

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      cand;
  logic               grant_found;
  logic               credit_ok;
  logic               issue;
  logic               pop;
  logic [CW-1:0]      credit_cnt;
  logic [SW-1:0]      sel_x;
  logic [SW-1:0]      sel_y;

  logic [MUL_LAT-1:0] tag_vld;
  logic [IW-1:0]      tag_idx [MUL_LAT];

  logic               fifo_valid;
  logic [IW+SW-1:0]   fifo_head;
  logic [CW-1:0]      fifo_count;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && ReqValidxSI[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A pop this cycle frees a slot at the same edge the new issue claims one,
  // which is what lets a depth of MUL_LAT+1 sustain one issue per cycle.
  assign pop       = fifo_valid & RspReadyxSI;
  assign credit_ok = (credit_cnt != '0) | pop;
  assign issue     = grant_found & RndValidxSI & credit_ok;

  // Grant and randomness consumption are tied to the same issue so a Z value
  // is never shared between two multiplications.
  always_comb begin
    ReqReadyxSO = '0;
    if (issue) ReqReadyxSO[grant_idx] = 1'b1;
  end
  assign RndReadyxSO = issue;

  assign sel_x = ReqXxDI[int'(grant_idx)*SW +: SW];
  assign sel_y = ReqYxDI[int'(grant_idx)*SW +: SW];

`ifdef DOM_SCHED_IDLE_ZERO_EN
  assign MulXxDO = issue ? sel_x  : '0;
  assign MulYxDO = issue ? sel_y  : '0;
  assign MulZxDO = issue ? RndxDI : '0;
`else
  logic [SW-1:0] hold_x;
  logic [SW-1:0] hold_y;
  logic [RW-1:0] hold_z;

  // Holding registers keep the multiplier inputs quiet between issues.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      hold_x <= '0;
      hold_y <= '0;
      hold_z <= '0;
    end else if (issue) begin
      hold_x <= sel_x;
      hold_y <= sel_y;
      hold_z <= RndxDI;
    end
  end

  assign MulXxDO = issue ? sel_x  : hold_x;
  assign MulYxDO = issue ? sel_y  : hold_y;
  assign MulZxDO = issue ? RndxDI : hold_z;
`endif

  // Pointer moves past the winner only when something is actually issued.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Credits = free FIFO slots not yet claimed by in-flight multiplications.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      credit_cnt <= CW'(RSP_DEP);
    end else begin
      case ({issue, pop})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Tag pipe mirrors the multiplier register stages.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      tag_vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= grant_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  dom_rsp_fifo #(
    .DEPTH (RSP_DEP),
    .WIDTH (IW + SW)
  ) u_rsp_fifo (
    .clk       (ClkxCI),
    .rst_n     (RstxBI),
    .push      (tag_vld[MUL_LAT-1]),
    .push_data ({tag_idx[MUL_LAT-1], MulQxDI}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // Head fields read as zero when nothing is queued.
  assign RspValidxSO = fifo_valid;
  assign RspIdxDO    = fifo_valid ? fifo_head[IW+SW-1:SW] : '0;
  assign RspQxDO     = fifo_valid ? fifo_head[SW-1:0]     : '0;

  // Stored entries plus free credits can never exceed the FIFO depth.
  a_credit_bound: assert property (@(posedge ClkxCI) disable iff (!RstxBI)
    (32'(credit_cnt) + 32'(fifo_count)) <= RSP_DEP);

endmodule

// File: tb/tb_dom_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_dom_mul_sched
//   Bench for dom_mul_sched (SHARES=2, NREQ=4, MUL_LAT=1, RSP_DEP=2) with a
//   registered two-share DOM GF(2^2) multiplier model. Expected responses
//   are queued at issue time; a monitor pops them when the DUT presents a
//   response. Honours DOM_SCHED_IDLE_ZERO_EN for the idle operand values.
// ---------------------------------------------------------------------------
module tb_dom_mul_sched;

  localparam int NREQ = 4;
  localparam int SW   = 4;
  localparam int RW   = 2;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SW-1:0]   req_x;
  logic [NREQ*SW-1:0]   req_y;
  logic [RW-1:0]        rnd;
  logic                 rnd_valid;
  logic                 rnd_ready;
  logic [SW-1:0]        mul_x;
  logic [SW-1:0]        mul_y;
  logic [RW-1:0]        mul_z;
  logic [SW-1:0]        mul_q;
  logic                 rsp_valid;
  logic [IW-1:0]        rsp_idx;
  logic [SW-1:0]        rsp_q;
  logic                 rsp_ready;

  int checks = 0;
  int errors = 0;

  logic [IW+1:0] exp_q [$];
  logic [IW+1:0] mon_e;

  logic [1:0] req_xv [NREQ];
  logic [1:0] req_yv [NREQ];
  logic [SW-1:0] last_x;
  logic [SW-1:0] last_y;
  logic [RW-1:0] last_z;

  logic [1:0] op_tab [8] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
  int op_k = 0;

  always #5 clk = ~clk;

  dom_mul_sched #(
    .SHARES  (2),
    .NREQ    (NREQ),
    .MUL_LAT (1),
    .RSP_DEP (2)
  ) dut (
    .ClkxCI      (clk),
    .RstxBI      (rst_n),
    .ReqValidxSI (req_valid),
    .ReqReadyxSO (req_ready),
    .ReqXxDI     (req_x),
    .ReqYxDI     (req_y),
    .RndxDI      (rnd),
    .RndValidxSI (rnd_valid),
    .RndReadyxSO (rnd_ready),
    .MulXxDO     (mul_x),
    .MulYxDO     (mul_y),
    .MulZxDO     (mul_z),
    .MulQxDI     (mul_q),
    .RspValidxSO (rsp_valid),
    .RspIdxDO    (rsp_idx),
    .RspQxDO     (rsp_q),
    .RspReadyxSI (rsp_ready)
  );

  // GF(2^2) with x^2+x+1: unshared reference product.
  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[1]),
            (a[0] & b[0]) ^ (a[1] & b[1])};
  endfunction

  // Two-share DOM multiplier, one register stage; shares recombine to X*Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_q <= '0;
    end else begin
      mul_q <= {gf_mul(mul_x[3:2], mul_y[3:2]) ^ gf_mul(mul_x[3:2], mul_y[1:0]) ^ mul_z,
                gf_mul(mul_x[1:0], mul_y[1:0]) ^ gf_mul(mul_x[1:0], mul_y[3:2]) ^ mul_z};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every presented-and-accepted response with the queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual=idx%0d required=none", rsp_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_idx", 32'(rsp_idx), 32'(mon_e[IW+1:2]));
        chk("rsp_q", 32'(rsp_q[1:0] ^ rsp_q[3:2]), 32'(mon_e[1:0]));
      end
    end
  end

  // Drive one requester with freshly masked operands from the table.
  task automatic set_req(input int r);
    logic [1:0] x, y, mx, my;
    x  = op_tab[op_k % 8];
    y  = op_tab[(op_k + 3) % 8];
    op_k++;
    mx = 2'($urandom_range(0, 3));
    my = 2'($urandom_range(0, 3));
    req_x[r*SW +: SW] = {x ^ mx, mx};
    req_y[r*SW +: SW] = {y ^ my, my};
    req_xv[r]    = x;
    req_yv[r]    = y;
    req_valid[r] = 1'b1;
  endtask

  task automatic apply_stimulus();
    rnd = 2'($urandom_range(0, 3));
  endtask

  // Check one cycle against the expected grant (-1 = no issue), then move to
  // just after the next rising edge.
  task automatic check_output(input int g);
    logic [NREQ-1:0] exp_rdy;
    logic [SW-1:0]   ex, ey;
    logic [IW-1:0]   gi;
    @(negedge clk);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rnd_ready", 32'(rnd_ready), (g >= 0) ? 32'd1 : 32'd0);
    if (g >= 0) begin
      ex = req_x[g*SW +: SW];
      ey = req_y[g*SW +: SW];
      gi = IW'(g);
      chk("mul_x_issue", 32'(mul_x), 32'(ex));
      chk("mul_y_issue", 32'(mul_y), 32'(ey));
      chk("mul_z_issue", 32'(mul_z), 32'(rnd));
      exp_q.push_back({gi, gf_mul(req_xv[g], req_yv[g])});
      last_x = ex;
      last_y = ey;
      last_z = rnd;
    end else begin
`ifdef DOM_SCHED_IDLE_ZERO_EN
      chk("mul_x_idle", 32'(mul_x), 32'd0);
      chk("mul_y_idle", 32'(mul_y), 32'd0);
      chk("mul_z_idle", 32'(mul_z), 32'd0);
`else
      chk("mul_x_idle", 32'(mul_x), 32'(last_x));
      chk("mul_y_idle", 32'(mul_y), 32'(last_y));
      chk("mul_z_idle", 32'(mul_z), 32'(last_z));
`endif
    end
    @(posedge clk);
    #1;
    apply_stimulus();
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    chk("rst_mul_x", 32'(mul_x), 32'd0);
    chk("rst_mul_y", 32'(mul_y), 32'd0);
    chk("rst_mul_z", 32'(mul_z), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_rsp_q", 32'(rsp_q), 32'd0);
  endtask

  // Idle until every queued response has been seen, bounded.
  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      check_output(-1);
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rnd       = '0;
    rnd_valid = 1'b0;
    rsp_ready = 1'b1;
    last_x    = '0;
    last_y    = '0;
    last_z    = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_xv[r] = '0;
      req_yv[r] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rnd_valid = 1'b1;
    apply_stimulus();
    $display("[TB] reset released");

    // Round robin with all four requesting
    for (int r = 0; r < NREQ; r++) set_req(r);
    foreach (op_tab[i]) begin
      if (i < 5) begin
        check_output(i % 4);
        set_req(i % 4);
      end
    end
    req_valid = '0;
    drain(20);

    // Single request 1 with X=2, Y=3 -> product 1
    req_x[1*SW +: SW] = {2'd2 ^ 2'd1, 2'd1};
    req_y[1*SW +: SW] = {2'd3 ^ 2'd2, 2'd2};
    req_xv[1] = 2'd2;
    req_yv[1] = 2'd3;
    req_valid[1] = 1'b1;
    check_output(1);
    req_valid = '0;
    drain(20);

    // Randomness starvation with requester 2 pending
    set_req(2);
    rnd_valid = 1'b0;
    repeat (3) check_output(-1);
    rnd_valid = 1'b1;
    check_output(2);
    req_valid = '0;
    drain(20);

    // Back-pressure: two issues fill the FIFO, then stall until released
    rsp_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) set_req(r);
    check_output(3);
    set_req(3);
    check_output(0);
    set_req(0);
    check_output(-1);
    @(negedge clk);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    check_output(-1);
    rsp_ready = 1'b1;
    check_output(1);
    set_req(1);
    check_output(2);
    set_req(2);
    check_output(3);
    req_valid = '0;
    drain(20);

    // Reset with one multiplication in flight
    set_req(0);
    check_output(0);
    req_valid = '0;
    rst_n = 1'b0;
    exp_q.delete();
    last_x = '0;
    last_y = '0;
    last_z = '0;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    repeat (2) check_output(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
